// File: rtl/cond_pkg.sv
// Condition-code package: flag bit indices, branch condition codes
// and the shared condition evaluator.
package cond_pkg;

  localparam int F_V = 0;
  localparam int F_C = 1;
  localparam int F_Z = 2;
  localparam int F_S = 3;

  localparam logic [3:0] COND_NV = 4'h0;
  localparam logic [3:0] COND_AL = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_EQ = 4'h4;
  localparam logic [3:0] COND_NE = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_MI = 4'h8;
  localparam logic [3:0] COND_PL = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_HI = 4'hE;
  localparam logic [3:0] COND_LS = 4'hF;

  function automatic logic cond_eval(
    input logic [3:0] sel,
    input logic [3:0] f
  );
    logic s, z, c, v, r;
    s = f[F_S];
    z = f[F_Z];
    c = f[F_C];
    v = f[F_V];
    r = 1'b0;
    case (sel)
      COND_NV: r = 1'b0;
      COND_AL: r = 1'b1;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_MI: r = s;
      COND_PL: r = ~s;
      COND_GE: r = (s == v);
      COND_LT: r = (s != v);
      COND_GT: r = ~z & (s == v);
      COND_LE: r = z | (s != v);
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_flag_unit_lifo.sv
// Flag LIFO: storage, occupancy count, full/empty and the
// simultaneous push/pop swap of the top entry.
module flag_lifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             take,
  output logic             err,
  output logic             empty,
  output logic             full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign top_idx = AW'(cnt - CW'(1));
  assign wr_idx  = AW'(cnt);
  assign top     = empty ? '0 : mem[top_idx];

  // push+pop on an empty stack degrades to a plain push
  assign do_swap = push & pop & ~empty;
  assign do_push = push & ~full & ~do_swap;
  assign do_pop  = pop & ~push & ~empty;
  assign take    = pop & ~empty;
  assign err     = (push & ~pop & full)
                 | (pop & ~push & empty);

  // entry storage and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (do_swap) begin
      mem[top_idx] <= din;
    end else if (do_push) begin
      mem[wr_idx] <= din;
      cnt         <= cnt + CW'(1);
    end else if (do_pop) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Flag register plus branch condition evaluator; optional
// interrupt flag stack enabled by FLAG_STACK_EN.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter bit CC_REG      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] flags_in,
  input  logic [3:0] flags_ld,
  input  logic [3:0] cond_sel,
  input  logic       eval,
  output logic       cc,
  output logic       cc_valid,
  output logic [3:0] flags_out,
  input  logic       push,
  input  logic       pop,
  output logic       stk_empty,
  output logic       stk_full,
  output logic       stk_err,
  input  logic       err_clr
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic [3:0] top;
  logic       take_top;

`ifdef FLAG_STACK_EN
  logic err_evt;
  logic err_q;

  flag_lifo #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (4)
  ) u_lifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (flags_q),
    .top   (top),
    .take  (take_top),
    .err   (err_evt),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // sticky stack error; a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= 1'b0;
    else if (err_evt)
      err_q <= 1'b1;
    else if (err_clr)
      err_q <= 1'b0;
  end

  assign stk_err = err_q;
`else
  localparam int unused_depth = STACK_DEPTH;
  logic unused_stk;

  assign unused_stk = ^{push, pop, err_clr};
  assign take_top   = 1'b0;
  assign top        = '0;
  assign stk_empty  = 1'b1;
  assign stk_full   = 1'b0;
  assign stk_err    = 1'b0;
`endif

  // restore from stack wins over per-bit loads
  always_comb begin
    flags_d = (flags_ld & flags_in)
            | (~flags_ld & flags_q);
    if (take_top)
      flags_d = top;
  end

  // flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flags_q <= '0;
    else
      flags_q <= flags_d;
  end

  assign flags_out = flags_q;

  generate
    if (CC_REG) begin : g_cc_reg
      logic cc_q;
      logic vld_q;

      // result latched from pre-load flags
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cc_q  <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= eval;
          if (eval)
            cc_q <= cond_eval(cond_sel, flags_q);
        end
      end

      assign cc       = cc_q;
      assign cc_valid = vld_q;
    end else begin : g_cc_comb
      assign cc       = cond_eval(cond_sel, flags_q);
      assign cc_valid = eval;
    end
  endgenerate

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit; cc results go through
// a scoreboard queue. Stack scenarios follow FLAG_STACK_EN.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] flags_in = '0;
  logic [3:0] flags_ld = '0;
  logic [3:0] cond_sel = '0;
  logic       eval = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       err_clr = 1'b0;
  logic       cc;
  logic       cc_valid;
  logic [3:0] flags_out;
  logic       stk_empty;
  logic       stk_full;
  logic       stk_err;

  int tests = 0;
  int fails = 0;
  logic exp_q[$];
  logic [3:0] stk_model[$];

  always #5 clk = ~clk;

  cond_flag_unit dut (
    .clk       (clk),
    .reset     (reset),
    .flags_in  (flags_in),
    .flags_ld  (flags_ld),
    .cond_sel  (cond_sel),
    .eval      (eval),
    .cc        (cc),
    .cc_valid  (cc_valid),
    .flags_out (flags_out),
    .push      (push),
    .pop       (pop),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .stk_err   (stk_err),
    .err_clr   (err_clr)
  );

  // reference: even codes give a base test, odd codes invert it
  function automatic logic model_cc(
    input logic [3:0] sel,
    input logic [3:0] f
  );
    logic s, z, c, v, b;
    {s, z, c, v} = f;
    case (sel[3:1])
      3'd0: b = 1'b0;
      3'd1: b = c;
      3'd2: b = z;
      3'd3: b = v;
      3'd4: b = s;
      3'd5: b = (s == v);
      3'd6: b = !z && (s == v);
      default: b = c && !z;
    endcase
    return b ^ sel[0];
  endfunction

  task automatic load_flags(input logic [3:0] v);
    flags_in = v;
    flags_ld = 4'hF;
    @(negedge clk);
    flags_ld = '0;
    flags_in = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (flags_out !== 4'h0) begin
      fails++;
      $display("FAIL reset_flags got=%h exp=0", flags_out);
    end
    tests++;
    if (cc !== 1'b0 || cc_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_cc got=%b/%b exp=0/0", cc, cc_valid);
    end
    tests++;
    if (stk_empty !== 1'b1 || stk_full !== 1'b0
        || stk_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_stk got=%b%b%b exp=100",
               stk_empty, stk_full, stk_err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic e;
    load_flags(4'hF);
    cond_sel = 4'h1;
    eval = 1'b1;
    exp_q.push_back(1'b1);
    @(negedge clk);
    eval = 1'b0;
    tests++;
    if (flags_out !== 4'hF) begin
      fails++;
      $display("FAIL basic_flags got=%h exp=f", flags_out);
    end
    tests++;
    if (cc_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_valid got=%b exp=1", cc_valid);
    end
    tests++;
    e = exp_q.pop_front();
    if (cc !== e) begin
      fails++;
      $display("FAIL basic_cc got=%b exp=%b", cc, e);
    end
    @(negedge clk);
    tests++;
    if (cc_valid !== 1'b0 || cc !== 1'b1) begin
      fails++;
      $display("FAIL basic_hold got=%b/%b exp=1/0",
               cc, cc_valid);
    end
  endtask

  task automatic test_signed();
    logic [3:0] fl [3] = '{4'h8, 4'h8, 4'hC};
    logic [3:0] sl [3] = '{4'hB, 4'hA, 4'hD};
    logic       ex [3] = '{1'b1, 1'b0, 1'b1};
    logic       e;
    for (int i = 0; i < 3; i++) begin
      load_flags(fl[i]);
      cond_sel = sl[i];
      eval = 1'b1;
      exp_q.push_back(ex[i]);
      @(negedge clk);
      eval = 1'b0;
      tests++;
      e = exp_q.pop_front();
      if (cc_valid !== 1'b1 || cc !== e) begin
        fails++;
        $display("FAIL signed_%0d got=%b/%b exp=%b/1",
                 i, cc, cc_valid, e);
      end
    end
  endtask

  task automatic test_preload();
    logic e;
    load_flags(4'h2);
    cond_sel = 4'h2;
    eval = 1'b1;
    flags_ld = 4'hF;
    flags_in = 4'h0;
    exp_q.push_back(1'b1);
    @(negedge clk);
    eval = 1'b0;
    flags_ld = '0;
    tests++;
    e = exp_q.pop_front();
    if (cc_valid !== 1'b1 || cc !== e) begin
      fails++;
      $display("FAIL preload_cc got=%b exp=%b", cc, e);
    end
    tests++;
    if (flags_out !== 4'h0) begin
      fails++;
      $display("FAIL preload_flags got=%h exp=0", flags_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] fv [6] =
      '{4'h0, 4'h5, 4'h8, 4'h9, 4'h6, 4'hF};
    logic e;
    foreach (fv[k]) begin
      load_flags(fv[k]);
      for (int s = 0; s < 16; s++) begin
        cond_sel = 4'(s);
        eval = 1'b1;
        exp_q.push_back(model_cc(4'(s), fv[k]));
        @(negedge clk);
        tests++;
        if (cc_valid !== 1'b1 || exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_valid f=%h s=%h got=%b exp=1",
                   fv[k], s, cc_valid);
        end else begin
          e = exp_q.pop_front();
          if (cc !== e) begin
            fails++;
            $display("FAIL b2b_cc f=%h s=%h got=%b exp=%b",
                     fv[k], s, cc, e);
          end
        end
      end
      eval = 1'b0;
    end
    @(negedge clk);
  endtask

`ifdef FLAG_STACK_EN
  task automatic test_stack();
    logic [3:0] vals [4] = '{4'h3, 4'h6, 4'hC, 4'h5};
    logic [3:0] e;
    stk_model.delete();
    foreach (vals[i]) begin
      load_flags(vals[i]);
      push = 1'b1;
      stk_model.push_back(vals[i]);
      @(negedge clk);
      push = 1'b0;
    end
    tests++;
    if (stk_full !== 1'b1 || stk_err !== 1'b0) begin
      fails++;
      $display("FAIL stk_full got=%b/%b exp=1/0",
               stk_full, stk_err);
    end
    load_flags(4'h9);
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    tests++;
    if (stk_err !== 1'b1 || stk_full !== 1'b1
        || flags_out !== 4'h9) begin
      fails++;
      $display("FAIL stk_ovf got=%b%b/%h exp=11/9",
               stk_err, stk_full, flags_out);
    end
    for (int i = 0; i < 4; i++) begin
      pop = 1'b1;
      flags_ld = 4'hF;
      flags_in = 4'h0;
      @(negedge clk);
      pop = 1'b0;
      flags_ld = '0;
      e = stk_model.pop_back();
      tests++;
      if (flags_out !== e) begin
        fails++;
        $display("FAIL stk_pop_%0d got=%h exp=%h",
                 i, flags_out, e);
      end
    end
    tests++;
    if (stk_empty !== 1'b1) begin
      fails++;
      $display("FAIL stk_empty got=%b exp=1", stk_empty);
    end
  endtask

  task automatic test_swap();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (stk_err !== 1'b0) begin
      fails++;
      $display("FAIL swap_clr got=%b exp=0", stk_err);
    end
    load_flags(4'hA);
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    load_flags(4'h5);
    push = 1'b1;
    pop = 1'b1;
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    tests++;
    if (flags_out !== 4'hA || stk_empty !== 1'b0
        || stk_full !== 1'b0) begin
      fails++;
      $display("FAIL swap_flags got=%h/%b exp=a/0",
               flags_out, stk_empty);
    end
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    tests++;
    if (flags_out !== 4'h5 || stk_empty !== 1'b1) begin
      fails++;
      $display("FAIL swap_top got=%h/%b exp=5/1",
               flags_out, stk_empty);
    end
    pop = 1'b1;
    flags_ld = 4'hF;
    flags_in = 4'h3;
    @(negedge clk);
    pop = 1'b0;
    flags_ld = '0;
    tests++;
    if (stk_err !== 1'b1 || flags_out !== 4'h3) begin
      fails++;
      $display("FAIL swap_udf got=%b/%h exp=1/3",
               stk_err, flags_out);
    end
    pop = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    tests++;
    if (stk_err !== 1'b1) begin
      fails++;
      $display("FAIL err_prio got=%b exp=1", stk_err);
    end
    @(negedge clk);
    err_clr = 1'b0;
    tests++;
    if (stk_err !== 1'b0) begin
      fails++;
      $display("FAIL err_clr got=%b exp=0", stk_err);
    end
    push = 1'b1;
    pop = 1'b1;
    flags_ld = 4'hF;
    flags_in = 4'h7;
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    flags_ld = '0;
    tests++;
    if (stk_err !== 1'b0 || stk_empty !== 1'b0
        || flags_out !== 4'h7) begin
      fails++;
      $display("FAIL pp_empty got=%b%b/%h exp=00/7",
               stk_err, stk_empty, flags_out);
    end
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    tests++;
    if (flags_out !== 4'h3 || stk_empty !== 1'b1) begin
      fails++;
      $display("FAIL pp_pop got=%h/%b exp=3/1",
               flags_out, stk_empty);
    end
  endtask
`else
  task automatic test_nostack();
    load_flags(4'h6);
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b1;
    err_clr = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    err_clr = 1'b0;
    tests++;
    if (flags_out !== 4'h6) begin
      fails++;
      $display("FAIL nostk_flags got=%h exp=6", flags_out);
    end
    tests++;
    if (stk_empty !== 1'b1 || stk_full !== 1'b0
        || stk_err !== 1'b0) begin
      fails++;
      $display("FAIL nostk_status got=%b%b%b exp=100",
               stk_empty, stk_full, stk_err);
    end
  endtask
`endif

  task automatic test_reset_mid();
    load_flags(4'hF);
`ifdef FLAG_STACK_EN
    push = 1'b1;
    @(negedge clk);
    push = 1'b0;
`endif
    cond_sel = 4'h1;
    eval = 1'b1;
    @(posedge clk);
    #1;
    eval = 1'b0;
    tests++;
    if (cc_valid !== 1'b1) begin
      fails++;
      $display("FAIL rmid_pre got=%b exp=1", cc_valid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (cc !== 1'b0 || cc_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_cc got=%b/%b exp=0/0",
               cc, cc_valid);
    end
    tests++;
    if (stk_empty !== 1'b1 || flags_out !== 4'h0) begin
      fails++;
      $display("FAIL rmid_state got=%b/%h exp=1/0",
               stk_empty, flags_out);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (cc_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_post got=%b exp=0", cc_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_preload();
    test_back_to_back();
`ifdef FLAG_STACK_EN
    test_stack();
    test_swap();
`else
    test_nostack();
`endif
    test_reset_mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
